// File: rtl/sisc_pkg.sv
// Shared constants and types for the SISC control unit: opcodes, ALU selects,
// status bit positions, FSM state encoding and the registered control bundle.
package sisc_pkg;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_ALU = 4'b0001;
  localparam logic [3:0] OP_LOD = 4'b0010;
  localparam logic [3:0] OP_STR = 4'b0011;
  localparam logic [3:0] OP_BRA = 4'b0100;
  localparam logic [3:0] OP_BRR = 4'b0101;
  localparam logic [3:0] OP_BNE = 4'b0110;
  localparam logic [3:0] OP_BNR = 4'b0111;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // alu_op[3:1] operation selects
  localparam logic [2:0] ALU_RR  = 3'b000;
  localparam logic [2:0] ALU_RI  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_RSB = 3'b111;

  // stat = {C,V,N,Z}
  localparam int STAT_Z = 0;
  localparam int STAT_N = 1;
  localparam int STAT_V = 2;
  localparam int STAT_C = 3;

  typedef enum logic [2:0] {
    S_START     = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM       = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6
  } state_e;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       ir_load;
    logic       pc_write;
    logic       pc_sel;
    logic       br_sel;
    logic       pc_rst;
    logic       rf_we;
    logic       wb_sel;
    logic       mm_sel;
    logic       dm_we;
    logic       halt;
  } ctrl_t;

  function automatic logic is_defined_op(input logic [3:0] op);
    return (op <= OP_BNR) || (op == OP_HLT);
  endfunction

endpackage

// File: rtl/sisc_br_eval.sv
// Branch condition evaluator: decides whether a branch opcode is taken given
// its mask field and the current {C,V,N,Z} status.
module sisc_br_eval
  import sisc_pkg::*;
(
  input  logic [3:0] op,
  input  logic [3:0] mm,
  input  logic [3:0] stat,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (op)
      OP_BRA, OP_BRR: taken = (mm == 4'b0000) || (|(mm & stat));
      OP_BNE, OP_BNR: taken = ~|(mm & stat);
      default:        taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/sisc_ctrl.sv
// Multi-cycle SISC control unit: START -> FETCH -> DECODE -> EXECUTE -> MEM -> WRITEBACK.
// Optional feature: define SISC_ILLEGAL_TRAP_EN to halt on undefined opcodes.
module sisc_ctrl
  import sisc_pkg::*;
#(
  parameter int INSTR_W      = 32,
  parameter int START_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] ir,
  input  logic [3:0]         stat,
  output logic [3:0]         alu_op,
  output logic               ir_load,
  output logic               pc_write,
  output logic               pc_sel,
  output logic               br_sel,
  output logic               pc_rst,
  output logic               rf_we,
  output logic               wb_sel,
  output logic               mm_sel,
  output logic               dm_we,
  output logic               halt,
  output logic [2:0]         state_dbg
);

`ifdef SISC_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam int CW = $clog2(START_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(START_CYCLES - 1);

  logic [3:0] op;
  logic [3:0] mm;
  logic       br_taken;
  logic       unused_ir;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  ctrl_t         ctrl_q, ctrl_d;

  assign op        = ir[INSTR_W-1 -: 4];
  assign mm        = ir[INSTR_W-5 -: 4];
  assign unused_ir = ^ir[INSTR_W-9:0];

  sisc_br_eval u_br_eval (
    .op    (op),
    .mm    (mm),
    .stat  (stat),
    .taken (br_taken)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl_d  = '0;

    case (state_q)
      S_START: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_FETCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FETCH:     state_d = S_DECODE;
      S_DECODE: begin
        if (op == OP_HLT || (TRAP_EN && !is_defined_op(op))) state_d = S_HALT;
        else                                                state_d = S_EXECUTE;
      end
      S_EXECUTE:   state_d = S_MEM;
      S_MEM:       state_d = S_WRITEBACK;
      S_WRITEBACK: state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_START;
    endcase

    // Outputs are Moore: computed for the state being entered, so the branch
    // decision is captured from stat on the DECODE -> EXECUTE edge.
    case (state_d)
      S_START: ctrl_d.pc_rst = 1'b1;
      S_FETCH: begin
        ctrl_d.ir_load  = 1'b1;
        ctrl_d.pc_write = 1'b1;
      end
      S_EXECUTE: begin
        case (op)
          OP_ALU: ctrl_d.alu_op = {(mm[3] ? ALU_RI : ALU_RR), 1'b1};
          OP_LOD, OP_STR: ctrl_d.alu_op = {ALU_ADD, 1'b0};
          OP_BRA, OP_BRR, OP_BNE, OP_BNR: begin
            ctrl_d.pc_write = br_taken;
            ctrl_d.pc_sel   = br_taken;
            ctrl_d.br_sel   = br_taken && (op == OP_BRA || op == OP_BNE);
          end
          default: ;
        endcase
      end
      S_MEM: begin
        if (op == OP_STR) begin
          ctrl_d.dm_we  = 1'b1;
          ctrl_d.mm_sel = mm[3];
        end else if (op == OP_LOD) begin
          ctrl_d.mm_sel = mm[3];
        end
      end
      S_WRITEBACK: begin
        if (op == OP_ALU) begin
          ctrl_d.rf_we = 1'b1;
        end else if (op == OP_LOD) begin
          // address source kept steady while the read data is written back
          ctrl_d.rf_we  = 1'b1;
          ctrl_d.wb_sel = 1'b1;
          ctrl_d.mm_sel = mm[3];
        end
      end
      S_HALT:  ctrl_d.halt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_START;
      cnt_q         <= '0;
      ctrl_q        <= '0;
      ctrl_q.pc_rst <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign alu_op    = ctrl_q.alu_op;
  assign ir_load   = ctrl_q.ir_load;
  assign pc_write  = ctrl_q.pc_write;
  assign pc_sel    = ctrl_q.pc_sel;
  assign br_sel    = ctrl_q.br_sel;
  assign pc_rst    = ctrl_q.pc_rst;
  assign rf_we     = ctrl_q.rf_we;
  assign wb_sel    = ctrl_q.wb_sel;
  assign mm_sel    = ctrl_q.mm_sel;
  assign dm_we     = ctrl_q.dm_we;
  assign halt      = ctrl_q.halt;
  assign state_dbg = state_q;

endmodule
